botao_sinalizador: RTL and testbench

Front-end press encoder that produces the `SinalBotao1` / `SinalBotao2` pulses consumed by `Botao2`. It synchronises two raw mechanical push-buttons and debounces each one independently. For every debounced press it emits exactly one single-cycle pulse, and it never asserts both outputs in the same cycle. It sits between the board's button pins and `Botao2`.

---
 rtl/botao_sinalizador.sv | 95 +++++++++
 tb/tb_botao_sinalizador.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/botao_sinalizador.sv
// Two-button press encoder: synchronises and debounces each raw button, then emits
// one single-cycle pulse per debounced press, never asserting both pulses together.
module botao_sinalizador #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BotaoBruto1,
  input  logic       BotaoBruto2,
  output logic       SinalBotao1,
  output logic       SinalBotao2,
  output logic [1:0] BotaoEstavel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} estado_t;

  logic [1:0] bruto;
  logic [1:0] press;
  estado_t    estado;
  logic       pend2;

  assign bruto = {BotaoBruto2, BotaoBruto1};

  for (genvar i = 0; i < 2; i++) begin : g_canal
    logic          sync_a;
    logic          s;
    logic          e;
    logic [CW-1:0] c;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a <= 1'b0;
        s      <= 1'b0;
        e      <= 1'b0;
        c      <= '0;
      end else begin
        sync_a <= bruto[i];
        s      <= sync_a;
        // Any sample agreeing with the stable level restarts the window.
        if (s == e) begin
          c <= '0;
        end else if (c == C_MAX) begin
          e <= s;
          c <= '0;
        end else begin
          c <= c + 1'b1;
        end
      end
    end

    // Only a rising commit counts as a press; release commits are silent.
    assign press[i]        = s && !e && (c == C_MAX);
    assign BotaoEstavel[i] = e;
  end

  // Arbiter: on a simultaneous press, button 1 goes first and button 2 follows
  // in the next cycle from the PEND state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= IDLE;
      pend2       <= 1'b0;
      SinalBotao1 <= 1'b0;
      SinalBotao2 <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          SinalBotao1 <= press[0];
          if (&press) begin
            SinalBotao2 <= 1'b0;
            pend2       <= 1'b1;
            estado      <= PEND;
          end else begin
            SinalBotao2 <= press[1];
          end
        end
        PEND: begin
          SinalBotao1 <= 1'b0;
          SinalBotao2 <= pend2;
          pend2       <= 1'b0;
          estado      <= IDLE;
        end
        default: begin
          SinalBotao1 <= 1'b0;
          SinalBotao2 <= 1'b0;
          pend2       <= 1'b0;
          estado      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_botao_sinalizador.sv
// Directed bench for botao_sinalizador with DEBOUNCE_CYCLES = 4: vector table for
// press/glitch/bounce/simultaneous cases plus reset sequences written by hand.
module tb_botao_sinalizador;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BotaoBruto1;
  logic       BotaoBruto2;
  logic       SinalBotao1;
  logic       SinalBotao2;
  logic [1:0] BotaoEstavel;

  int checks = 0;
  int errors = 0;

  // Expected word layout: {SinalBotao1, SinalBotao2, BotaoEstavel[1], BotaoEstavel[0]}
  typedef struct {
    logic  b1;
    logic  b2;
    string name;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  botao_sinalizador #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .BotaoBruto1  (BotaoBruto1),
    .BotaoBruto2  (BotaoBruto2),
    .SinalBotao1  (SinalBotao1),
    .SinalBotao2  (SinalBotao2),
    .BotaoEstavel (BotaoEstavel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {SinalBotao1, SinalBotao2, BotaoEstavel};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got s1s2est=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic b1, input logic b2, input logic [3:0] exp, input string name);
    vec_t v;
    v.b1   = b1;
    v.b2   = b2;
    v.name = name;
    vecs.push_back(v);
    exp_q.push_back(exp);
  endtask

  // Buttons held from reset release: pulses on edges 5 and 6, level 11 from edge 5.
  task automatic held_after_release(input string tag);
    logic [3:0] e;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 5)      e = 4'b1011;
      else if (k == 6) e = 4'b0111;
      else if (k > 6)  e = 4'b0011;
      else             e = 4'b0000;
      check($sformatf("%s_edge%0d", tag, k), e);
    end
    BotaoBruto1 = 1'b0;
    BotaoBruto2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("%s_release%0d", tag, k), (k < 5) ? 4'b0011 : 4'b0000);
    end
  endtask

  initial begin
    logic [6:0] pat;
    vec_t       v;

    // Clean press of button 1, held 20 cycles, then released.
    for (int r = 0; r < 30; r++)
      add(r < 20, 1'b0, {r == 5, 1'b0, 1'b0, (r >= 5 && r < 25)}, $sformatf("press1_r%0d", r));
    // Glitch of 3 samples is rejected.
    for (int r = 0; r < 10; r++)
      add(r < 3, 1'b0, 4'b0000, $sformatf("glitch1_r%0d", r));
    // Bouncing button 2 (1,1,0,1,1,0,1 then steady 1 from row 6), later released.
    pat = 7'b1011011;
    for (int r = 0; r < 28; r++)
      add(1'b0, (r < 7) ? pat[r] : (r < 21), {1'b0, r == 11, (r >= 11 && r < 26), 1'b0},
          $sformatf("bounce2_r%0d", r));
    // Both buttons pressed on the same edge, then released together.
    for (int r = 0; r < 19; r++)
      add(r < 12, r < 12, {r == 5, r == 6, (r >= 5 && r < 17), (r >= 5 && r < 17)},
          $sformatf("simul_r%0d", r));

    // Asynchronous reset with both buttons held.
    rst_n       = 1'b0;
    BotaoBruto1 = 1'b1;
    BotaoBruto2 = 1'b1;
    #3;
    check("reset_async", 4'b0000);
    repeat (3) step();
    check("reset_held", 4'b0000);
    rst_n = 1'b1;
    held_after_release("reset_rel");

    for (int i = 0; i < vecs.size(); i++) begin
      v           = vecs[i];
      BotaoBruto1 = v.b1;
      BotaoBruto2 = v.b2;
      step();
      check(v.name, exp_q.pop_front());
    end

    // Reset while the second pulse of a simultaneous press is pending.
    BotaoBruto1 = 1'b1;
    BotaoBruto2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("pend_edge%0d", k), (k == 5) ? 4'b1011 : 4'b0000);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("pend_async_reset", 4'b0000);
    step();
    check("pend_lost_s2", 4'b0000);
    rst_n = 1'b1;
    held_after_release("pend_rel");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
